// File: rtl/vector_element_sequencer.sv
// Walks one vector instruction's element groups across NUM_LANES lanes and tracks groups in flight.
// Optional VSEQ_PERF_CNT_EN adds stall_cycles/issue_cycles performance counters.
module vector_element_sequencer #(
  parameter int NUM_LANES = 2,
  parameter int VL_W      = 8,
  parameter int MAX_OUT   = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic [VL_W-1:0]      vl,
  input  logic                 vd_widen,
  input  logic                 stall,
  input  logic                 retire,
  input  logic                 flush,
  output logic                 ready,
  output logic                 busy,
  output logic                 issue_valid,
  output logic [VL_W-1:0]      elem_idx,
  output logic [NUM_LANES-1:0] lane_en,
  output logic [VL_W:0]        vd_offset,
  output logic                 last,
  output logic                 done,
  output logic                 retire_err,
`ifdef VSEQ_PERF_CNT_EN
  output logic [15:0]          stall_cycles,
  output logic [15:0]          issue_cycles,
`endif
  output logic [1:0]           state_dbg
);

  // Handshake: start is consumed on any cycle where ready=1 and flush=0.
  // issue_valid has no ready; stall is the only downstream back-pressure.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  localparam int CW = VL_W + 4;
  localparam logic [3:0] MAX_C = 4'(MAX_OUT);

  state_t          state_q, state_d;
  logic [VL_W:0]   base_q, base_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic            widen_q, widen_d;
  logic [3:0]      out_q, out_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            start_acc;
  logic            is_last;

  assign ready      = (state_q == IDLE);
  assign busy       = ~ready;
  assign done       = done_q;
  assign retire_err = err_q;
  assign state_dbg  = state_q;
  assign start_acc  = ready && start && !flush;
  assign is_last    = (CW'(base_q) + CW'(NUM_LANES)) >= CW'(vl_q);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    vl_d        = vl_q;
    widen_d     = widen_q;
    out_d       = out_q;
    done_d      = 1'b0;
    err_d       = err_q;
    issue_valid = 1'b0;
    elem_idx    = '0;
    lane_en     = '0;
    vd_offset   = '0;
    last        = 1'b0;

    if (state_q == ISSUE && !stall && !flush && out_q < MAX_C) begin
      issue_valid = 1'b1;
      elem_idx    = base_q[VL_W-1:0];
      for (int i = 0; i < NUM_LANES; i++)
        lane_en[i] = (CW'(base_q) + CW'(i)) < CW'(vl_q);
      vd_offset   = widen_q ? {base_q[VL_W-1:0], 1'b0} : {1'b0, base_q[VL_W-1:0]};
      last        = is_last;
    end

    if (start_acc) err_d = 1'b0;

    // Simultaneous issue and retire leaves the count unchanged.
    if (issue_valid && !retire) begin
      out_d = out_q + 4'd1;
    end else if (!issue_valid && retire) begin
      if (out_q != 4'd0) out_d = out_q - 4'd1;
      else               err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          vl_d    = vl;
          widen_d = vd_widen;
          base_d  = '0;
          if (vl != '0) state_d = ISSUE;
          else          done_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (issue_valid) begin
          base_d = base_q + (VL_W+1)'(NUM_LANES);
          if (is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_d == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush aborts everything, including any retire bookkeeping this cycle.
    if (flush) begin
      state_d = IDLE;
      base_d  = '0;
      out_d   = '0;
      done_d  = 1'b0;
      err_d   = err_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      base_q  <= '0;
      vl_q    <= '0;
      widen_q <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      vl_q    <= vl_d;
      widen_q <= widen_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef VSEQ_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (!nRST || start_acc) begin
      stall_cycles <= '0;
      issue_cycles <= '0;
    end else begin
      if (state_q == ISSUE && !issue_valid && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (issue_valid && issue_cycles != 16'hFFFF)
        issue_cycles <= issue_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Directed bench for vector_element_sequencer: instance a uses MAX_OUT=4, instance b MAX_OUT=1.
module tb_vector_element_sequencer;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       start, start_b, vd_widen, stall, retire, flush;
  logic [7:0] vl;

  logic       ready_a, busy_a, iv_a, last_a, done_a, err_a;
  logic [7:0] idx_a;
  logic [1:0] lane_a, st_a;
  logic [8:0] vd_a;
  logic       ready_b, busy_b, iv_b, last_b, done_b, err_b;
  logic [7:0] idx_b;
  logic [1:0] lane_b, st_b;
  logic [8:0] vd_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  vector_element_sequencer #(.NUM_LANES(2), .VL_W(8), .MAX_OUT(4)) dut_a (
    .CLK(CLK), .nRST(nRST), .start(start), .vl(vl), .vd_widen(vd_widen),
    .stall(stall), .retire(retire), .flush(flush), .ready(ready_a), .busy(busy_a),
    .issue_valid(iv_a), .elem_idx(idx_a), .lane_en(lane_a), .vd_offset(vd_a),
    .last(last_a), .done(done_a), .retire_err(err_a), .state_dbg(st_a)
  );

  vector_element_sequencer #(.NUM_LANES(2), .VL_W(8), .MAX_OUT(1)) dut_b (
    .CLK(CLK), .nRST(nRST), .start(start_b), .vl(vl), .vd_widen(vd_widen),
    .stall(stall), .retire(retire), .flush(flush), .ready(ready_b), .busy(busy_b),
    .issue_valid(iv_b), .elem_idx(idx_b), .lane_en(lane_b), .vd_offset(vd_b),
    .last(last_b), .done(done_b), .retire_err(err_b), .state_dbg(st_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue-side outputs of instance a: {issue_valid, elem_idx, lane_en, vd_offset, last}
  task automatic chk_a(input string tag, input logic iv, input logic [7:0] idx,
                       input logic [1:0] lane, input logic [8:0] vd, input logic lst);
    chk({tag, ".iv"},   32'(iv_a),   32'(iv));
    chk({tag, ".idx"},  32'(idx_a),  32'(idx));
    chk({tag, ".lane"}, 32'(lane_a), 32'(lane));
    chk({tag, ".vd"},   32'(vd_a),   32'(vd));
    chk({tag, ".last"}, 32'(last_a), 32'(lst));
  endtask

  task automatic chk_b(input string tag, input logic iv, input logic [7:0] idx,
                       input logic [1:0] lane, input logic lst);
    chk({tag, ".iv"},   32'(iv_b),   32'(iv));
    chk({tag, ".idx"},  32'(idx_b),  32'(idx));
    chk({tag, ".lane"}, 32'(lane_b), 32'(lane));
    chk({tag, ".last"}, 32'(last_b), 32'(lst));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; start_b = 1'b0; vl = '0; vd_widen = 1'b0;
    stall = 1'b0; retire = 1'b0; flush = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    #1;
    chk("rst.ready", 32'(ready_a), 32'd1);
    chk("rst.busy",  32'(busy_a),  32'd0);
    chk("rst.done",  32'(done_a),  32'd0);
    chk("rst.err",   32'(err_a),   32'd0);
    chk("rst.state", 32'(st_a),    32'd0);
    chk_a("rst", 1'b0, 8'd0, 2'b00, 9'd0, 1'b0);

    // vl=5: groups at 0,2,4; each retired two cycles after issue
    start = 1'b1; vl = 8'd5; tick();
    start = 1'b0; #1;
    chk_a("v5.c1", 1'b1, 8'd0, 2'b11, 9'd0, 1'b0);
    chk("v5.c1.state", 32'(st_a), 32'd1);
    tick(); #1;
    chk_a("v5.c2", 1'b1, 8'd2, 2'b11, 9'd2, 1'b0);
    tick(); retire = 1'b1; #1;
    chk_a("v5.c3", 1'b1, 8'd4, 2'b01, 9'd4, 1'b1);
    tick(); #1;
    chk_a("v5.c4", 1'b0, 8'd0, 2'b00, 9'd0, 1'b0);
    chk("v5.c4.state", 32'(st_a), 32'd2);
    chk("v5.c4.busy",  32'(busy_a), 32'd1);
    tick(); #1;
    chk("v5.c5.done", 32'(done_a), 32'd0);
    tick(); retire = 1'b0; #1;
    chk("v5.c6.done",  32'(done_a),  32'd1);
    chk("v5.c6.ready", 32'(ready_a), 32'd1);
    chk("v5.c6.err",   32'(err_a),   32'd0);
    tick(); #1;
    chk("v5.c7.done", 32'(done_a), 32'd0);

    // vl=8 widening, no retire: four groups fill MAX_OUT, then drain on four retires
    start = 1'b1; vl = 8'd8; vd_widen = 1'b1; tick();
    start = 1'b0; vd_widen = 1'b0; #1;
    chk_a("v8.g0", 1'b1, 8'd0, 2'b11, 9'd0, 1'b0);
    tick(); #1;
    chk_a("v8.g1", 1'b1, 8'd2, 2'b11, 9'd4, 1'b0);
    tick(); #1;
    chk_a("v8.g2", 1'b1, 8'd4, 2'b11, 9'd8, 1'b0);
    tick(); #1;
    chk_a("v8.g3", 1'b1, 8'd6, 2'b11, 9'd12, 1'b1);
    tick(); #1;
    chk_a("v8.drain", 1'b0, 8'd0, 2'b00, 9'd0, 1'b0);
    chk("v8.drain.state", 32'(st_a), 32'd2);
    tick(); retire = 1'b1; #1;
    chk("v8.r1.busy", 32'(busy_a), 32'd1);
    tick(); #1;
    tick(); #1;
    tick(); #1;
    chk("v8.r4.done", 32'(done_a), 32'd0);
    tick(); retire = 1'b0; #1;
    chk("v8.done",  32'(done_a),  32'd1);
    chk("v8.ready", 32'(ready_a), 32'd1);
    chk("v8.err",   32'(err_a),   32'd0);

    // instance b, MAX_OUT=1, vl=6, stall in cycles 2-3
    tick();
    start_b = 1'b1; vl = 8'd6; tick();
    start_b = 1'b0; #1;
    chk_b("b6.c1", 1'b1, 8'd0, 2'b11, 1'b0);
    tick(); stall = 1'b1; #1;
    chk_b("b6.c2", 1'b0, 8'd0, 2'b00, 1'b0);
    tick(); retire = 1'b1; #1;
    chk_b("b6.c3", 1'b0, 8'd0, 2'b00, 1'b0);
    tick(); stall = 1'b0; retire = 1'b0; #1;
    chk_b("b6.c4", 1'b1, 8'd2, 2'b11, 1'b0);
    tick(); retire = 1'b1; #1;
    chk_b("b6.c5", 1'b0, 8'd0, 2'b00, 1'b0);
    tick(); retire = 1'b0; #1;
    chk_b("b6.c6", 1'b1, 8'd4, 2'b11, 1'b1);
    tick(); retire = 1'b1; #1;
    chk_b("b6.c7", 1'b0, 8'd0, 2'b00, 1'b0);
    chk("b6.c7.done", 32'(done_b), 32'd0);
    tick(); retire = 1'b0; #1;
    chk("b6.done",  32'(done_b),  32'd1);
    chk("b6.err",   32'(err_b),   32'd0);
    chk("a.idle_retire.err", 32'(err_a), 32'd1);

    // vl=0 on a: no issue, done next cycle, start clears retire_err
    start = 1'b1; vl = 8'd0; #1;
    chk("v0.ready", 32'(ready_a), 32'd1);
    tick(); start = 1'b0; retire = 1'b1; #1;
    chk_a("v0.c1", 1'b0, 8'd0, 2'b00, 9'd0, 1'b0);
    chk("v0.done",  32'(done_a),  32'd1);
    chk("v0.ready1", 32'(ready_a), 32'd1);
    chk("v0.errclr", 32'(err_a),  32'd0);
    tick(); retire = 1'b0; #1;
    chk("v0.c2.done", 32'(done_a), 32'd0);
    chk("v0.c2.err",  32'(err_a),  32'd1);

    // vl=9, flush after second issue; then vl=2 completes normally
    start = 1'b1; vl = 8'd9; tick();
    start = 1'b0; #1;
    chk("v9.errclr", 32'(err_a), 32'd0);
    chk_a("v9.g0", 1'b1, 8'd0, 2'b11, 9'd0, 1'b0);
    tick(); #1;
    chk_a("v9.g1", 1'b1, 8'd2, 2'b11, 9'd2, 1'b0);
    tick(); flush = 1'b1; #1;
    chk_a("v9.flush", 1'b0, 8'd0, 2'b00, 9'd0, 1'b0);
    tick(); flush = 1'b0; #1;
    chk("v9.ready", 32'(ready_a), 32'd1);
    chk("v9.state", 32'(st_a),    32'd0);
    chk("v9.nodone", 32'(done_a), 32'd0);
    start = 1'b1; vl = 8'd2; tick();
    start = 1'b0; #1;
    chk("v9.nodone2", 32'(done_a), 32'd0);
    chk_a("v2.g0", 1'b1, 8'd0, 2'b11, 9'd0, 1'b1);
    tick(); retire = 1'b1; #1;
    chk("v2.drain", 32'(st_a), 32'd2);
    tick(); retire = 1'b0; #1;
    chk("v2.done",  32'(done_a),  32'd1);
    chk("v2.ready", 32'(ready_a), 32'd1);
    chk("v2.err",   32'(err_a),   32'd0);
    tick(); #1;
    chk("v2.done_off", 32'(done_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
